lsu_rmw_ctrl: RTL
=================

Name: lsu_rmw_ctrl

Overview:
- Sequences data-memory accesses from the LSU towards an ECC-protected data memory that supports only full-word writes.
- Full-word loads and stores go through in one bus transaction. Byte and halfword stores become an atomic read-merge-write pair.
- Sits between the LSU request stage and the data bus. Owns the LSU_RMW_* sequencing, so the LSU datapath needs no knowledge of memory protection.

Parameters:
- LOCK_RMW, 1, when 1 assert m_lock_o across the read and write of an RMW pair.
- MISALIGN_ERR, 1, when 1 a misaligned request returns an error without touching memory. When 0, address bits below the access size are ignored.

Ports:
- s_clk_i  in  1  core clock
- s_resetn_i  in  1  reset, asynchronous, active-low
- s_req_i  in  1  LSU request valid; held stable until accepted
- s_we_i  in  1  1 = store, 0 = load
- s_addr_i  in  32  byte address
- s_size_i  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
- s_wdata_i  in  32  store data, right-aligned
- s_rdy_o  out  1  request accepted when s_req_i & s_rdy_o
- s_rvalid_o  out  1  one-cycle response pulse
- s_rdata_o  out  32  full memory word for loads; 0 for stores
- s_err_o  out  1  response error, valid with s_rvalid_o
- m_req_o  out  1  memory request
- m_we_o  out  1  memory write
- m_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- m_wdata_o  out  32  write word
- m_lock_o  out  1  bus lock during RMW
- m_gnt_i  in  1  request granted this cycle
- m_rvalid_i  in  1  data-phase completion
- m_rdata_i  in  32  read word
- m_err_i  in  1  bus or uncorrectable error, valid with m_rvalid_i

Behaviour:
- Reset: state IDLE; all outputs 0 except s_rdy_o = 1; internal registers cleared.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
- IDLE:
  - s_rdy_o = 1 only in IDLE. On accept, register addr, size, we and data.
  - Illegal size, or misaligned with MISALIGN_ERR = 1 (half: addr[0]; word: addr[1:0] != 0) -> RESP with err = 1.
  - Load -> RD_REQ.
  - Word store -> WR_REQ with m_wdata_o = wdata.
  - Byte/half store -> RD_REQ with rmw flag set.
- RD_REQ: m_req_o = 1, m_we_o = 0, held until m_gnt_i -> RD_WAIT.
- RD_WAIT: wait for m_rvalid_i, then:
  - Load -> RESP with rdata = m_rdata_i, err = m_err_i.
  - RMW with m_err_i = 1 -> RESP err = 1. The write is never issued.
  - RMW with m_err_i = 0 -> merge, then WR_REQ.
- Merge:
  - Byte: lane addr[1:0] replaced by wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} replaced by wdata[15:0].
  - All other bytes come from the read word. The merged word is registered.
- WR_REQ: m_req_o = 1, m_we_o = 1, held until m_gnt_i -> WR_WAIT.
- WR_WAIT: on m_rvalid_i -> RESP with err = m_err_i.
- RESP: s_rvalid_o = 1 for exactly one cycle -> IDLE. A new request can be accepted in the next cycle.
- Registered outputs; m_addr_o and m_wdata_o stay stable while m_req_o = 1.
- Zero-wait latency (gnt in first request cycle, rvalid next cycle), with accept in cycle T:
  - Load / word store: s_rvalid_o at T+3.
  - RMW: s_rvalid_o at T+5.
  - Misaligned: s_rvalid_o at T+1.
- m_lock_o = LOCK_RMW & rmw, from RD_REQ entry until WR_WAIT exit (or RD_WAIT exit on error).
- m_rvalid_i outside RD_WAIT/WR_WAIT is ignored; the bench asserts it never occurs.
- m_gnt_i without m_req_o is ignored.
- Reset mid-operation: immediate return to IDLE and all outputs cleared. The in-flight memory transaction is abandoned and the memory side must tolerate this.
- Back-to-back requests: never more than one outstanding; s_rdy_o = 0 in all non-IDLE states.

Decomposition:
- p_hardisc changes:
  - Replace the 2-bit LSU_RMW_* constants with a 3-bit lsu_rmw_state typedef for the six states above.
  - Add typedef lsu_size with constants LSU_SIZE_B/H/W.
- Sub-module rmw_merge: combinational byte-lane merge of read word, store data, addr[1:0] and size. Reused by the LSU unit tests.

Test Plan:
- Word store 0x0000_1000 = 0xDEADBEEF, gnt/rvalid zero-wait -> single write, m_wdata_o = 0xDEADBEEF, m_lock_o = 0, s_rvalid_o at T+3, err = 0.
- Byte store addr 0x1002 data 0xAB, memory holds 0x11223344 -> read then write of 0x11AB3344 to 0x1000, m_lock_o high throughout both, s_rvalid_o at T+5.
- Halfword store addr 0x1001 -> no memory request, s_rvalid_o at T+1 with s_err_o = 1. Repeat with MISALIGN_ERR = 0 -> RMW on lanes 0-1.
- Byte-store RMW with m_err_i = 1 on the read -> no write issued, s_err_o = 1, m_lock_o drops after RD_WAIT.
- Load at 0x2000 with gnt delayed 3 cycles and rvalid delayed 2 -> m_req_o and m_addr_o stable until gnt, s_rdata_o = memory word, s_rdy_o = 0 throughout.
- Assert s_resetn_i low during WR_REQ of an RMW -> all outputs 0 immediately, s_rdy_o = 1 after release, next request served normally.

Source files
------------

// File: rtl/lsu_rmw_ctrl_pkg.sv
// rtl/lsu_rmw_ctrl_pkg.sv - shared types and helpers for the LSU read-merge-write sequencer
package lsu_rmw_ctrl_pkg;

    typedef enum logic [2:0] {
        LSU_RMW_IDLE    = 3'd0,
        LSU_RMW_RD_REQ  = 3'd1,
        LSU_RMW_RD_WAIT = 3'd2,
        LSU_RMW_WR_REQ  = 3'd3,
        LSU_RMW_WR_WAIT = 3'd4,
        LSU_RMW_RESP    = 3'd5
    } lsu_rmw_state;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'd0,
        LSU_SIZE_H = 2'd1,
        LSU_SIZE_W = 2'd2
    } lsu_size;

    localparam logic [1:0] LSU_SIZE_ILLEGAL = 2'd3;

    // True when the low address bits do not match the natural alignment of the access size.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (size == LSU_SIZE_H) begin
            mis = addr_lo[0];
        end else if (size == LSU_SIZE_W) begin
            mis = (addr_lo != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_rmw_ctrl_rmw_merge.sv
// rtl/lsu_rmw_ctrl_rmw_merge.sv - byte-lane merge of store data into a read memory word
module rmw_merge
    import lsu_rmw_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    output logic [31:0] merged
);

    // Start from the read word and overwrite only the lanes the store targets.
    always_comb begin
        merged = rdata;
        if (size == LSU_SIZE_B) begin
            merged[{addr, 3'b000} +: 8] = wdata[7:0];
        end else if (size == LSU_SIZE_H) begin
            merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
        end else if (size == LSU_SIZE_W) begin
            merged = wdata;
        end
    end

endmodule

// File: rtl/lsu_rmw_ctrl.sv
// rtl/lsu_rmw_ctrl.sv - sequences LSU accesses, turning sub-word stores into locked read-merge-write pairs
module lsu_rmw_ctrl
    import lsu_rmw_ctrl_pkg::*;
#(
    parameter bit LOCK_RMW     = 1'b1,
    parameter bit MISALIGN_ERR = 1'b1
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_req_i,
    input  logic        s_we_i,
    input  logic [31:0] s_addr_i,
    input  logic [1:0]  s_size_i,
    input  logic [31:0] s_wdata_i,
    output logic        s_rdy_o,
    output logic        s_rvalid_o,
    output logic [31:0] s_rdata_o,
    output logic        s_err_o,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    output logic        m_lock_o,
    input  logic        m_gnt_i,
    input  logic        m_rvalid_i,
    input  logic [31:0] m_rdata_i,
    input  logic        m_err_i
);

    lsu_rmw_state state_q, state_d;
    logic [31:0]  addr_q;
    logic [1:0]   size_q;
    logic         rmw_q;
    logic [31:0]  mwdata_q;
    logic [31:0]  rdata_q;
    logic         err_q;
    logic [31:0]  merged;
    logic         bad_req;
    logic         in_flight;

    // Requests that must never reach memory: illegal size, or misaligned when that is an error.
    assign bad_req = (s_size_i == LSU_SIZE_ILLEGAL) ||
                     (MISALIGN_ERR && lsu_misaligned(s_size_i, s_addr_i[1:0]));

    // mwdata_q holds the raw store data until the read returns, then the merged word.
    rmw_merge u_merge (
        .rdata  (m_rdata_i),
        .wdata  (mwdata_q),
        .addr   (addr_q[1:0]),
        .size   (size_q),
        .merged (merged)
    );

    // State register.
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_q <= LSU_RMW_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a failed RMW read skips the write entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_RMW_IDLE: begin
                if (s_req_i) begin
                    if (bad_req) begin
                        state_d = LSU_RMW_RESP;
                    end else if (s_we_i && (s_size_i == LSU_SIZE_W)) begin
                        state_d = LSU_RMW_WR_REQ;
                    end else begin
                        state_d = LSU_RMW_RD_REQ;
                    end
                end
            end
            LSU_RMW_RD_REQ:  if (m_gnt_i) state_d = LSU_RMW_RD_WAIT;
            LSU_RMW_RD_WAIT: if (m_rvalid_i) state_d = (rmw_q && !m_err_i) ? LSU_RMW_WR_REQ : LSU_RMW_RESP;
            LSU_RMW_WR_REQ:  if (m_gnt_i) state_d = LSU_RMW_WR_WAIT;
            LSU_RMW_WR_WAIT: if (m_rvalid_i) state_d = LSU_RMW_RESP;
            LSU_RMW_RESP:    state_d = LSU_RMW_IDLE;
            default:         state_d = LSU_RMW_IDLE;
        endcase
    end

    // Request capture, load data / merge capture and response status.
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            addr_q   <= '0;
            size_q   <= '0;
            rmw_q    <= 1'b0;
            mwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                LSU_RMW_IDLE: begin
                    if (s_req_i) begin
                        addr_q   <= s_addr_i;
                        size_q   <= s_size_i;
                        rmw_q    <= s_we_i && ((s_size_i == LSU_SIZE_B) || (s_size_i == LSU_SIZE_H));
                        mwdata_q <= s_we_i ? s_wdata_i : 32'h0;
                        rdata_q  <= '0;
                        err_q    <= bad_req;
                    end
                end
                LSU_RMW_RD_WAIT: begin
                    if (m_rvalid_i) begin
                        if (!rmw_q) begin
                            rdata_q <= m_rdata_i;
                            err_q   <= m_err_i;
                        end else if (m_err_i) begin
                            err_q <= 1'b1;
                        end else begin
                            mwdata_q <= merged;
                        end
                    end
                end
                LSU_RMW_WR_WAIT: begin
                    if (m_rvalid_i) begin
                        err_q <= m_err_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_flight  = (state_q == LSU_RMW_RD_REQ) || (state_q == LSU_RMW_RD_WAIT) ||
                        (state_q == LSU_RMW_WR_REQ) || (state_q == LSU_RMW_WR_WAIT);

    assign s_rdy_o    = (state_q == LSU_RMW_IDLE);
    assign s_rvalid_o = (state_q == LSU_RMW_RESP);
    assign s_rdata_o  = rdata_q;
    assign s_err_o    = err_q;
    assign m_req_o    = (state_q == LSU_RMW_RD_REQ) || (state_q == LSU_RMW_WR_REQ);
    assign m_we_o     = (state_q == LSU_RMW_WR_REQ);
    assign m_addr_o   = {addr_q[31:2], 2'b00};
    assign m_wdata_o  = mwdata_q;
    assign m_lock_o   = LOCK_RMW && rmw_q && in_flight;

endmodule
